// File: rtl/riscv_v_pipe_ctrl_if.sv
// Handshake and control bundle between the vector pipeline sequencer and
// its surroundings. The master side drives upstream/downstream requests and
// the slave side (the sequencer) returns enables, flush and status.
interface riscv_v_pipe_ctrl_if #(
  parameter int NUM_STAGES = 1,
  parameter int OCC_W      = $clog2(NUM_STAGES + 1)
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  stall;
  logic                  flush;
  logic                  drain_req;
  logic                  resume;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  stage_flush;
  logic [NUM_STAGES-1:0] valid;
  logic [OCC_W-1:0]      occupancy;
  logic                  drain_done;

  modport master (
    output in_valid, out_ready, stall, flush, drain_req, resume,
    input  in_ready, out_valid, stage_en, stage_flush, valid, occupancy, drain_done
  );

  modport slave (
    input  in_valid, out_ready, stall, flush, drain_req, resume,
    output in_ready, out_valid, stage_en, stage_flush, valid, occupancy, drain_done
  );
endinterface

// File: rtl/riscv_v_pipe_ctrl.sv
// Valid/ready sequencer for a chain of vector pipeline stage registers.
// Stage 1 (bit 0) is the input side, stage NUM_STAGES is the output side.
// Produces per-stage load enables, a common flush strobe, per-stage valid
// bits with bubble collapse, and a RUN/DRAIN/DONE drain handshake used
// before vstart/vtype reconfiguration.
module riscv_v_pipe_ctrl #(
  parameter int NUM_STAGES = 1,
  parameter int OCC_W      = $clog2(NUM_STAGES + 1)
) (
  input logic             clk,
  input logic             rst,   // asynchronous, active-low
  riscv_v_pipe_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [NUM_STAGES-1:0] adv;
  logic                  go;
  logic                  downstream_go;
  logic                  in_ready;
  logic                  take;
  logic [NUM_STAGES:0]   feed;

  // Advance chain: walk from the output stage back to the input stage; a
  // stage may load when it is empty or its successor is also moving.
  // NOTE: combinational blocks use blocking '=' so the running value of
  // downstream_go is seen by the next loop iteration; every variable gets
  // a default first so no latch is inferred.
  always_comb begin
    go            = !bus.stall && !bus.flush;
    adv           = '0;
    downstream_go = bus.out_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      adv[k]        = go && (!valid_q[k] || downstream_go);
      downstream_go = adv[k];
    end
  end

  // Acceptance into stage 1 only while running; forced low during reset.
  always_comb begin
    in_ready = rst && adv[0] && (state_q == ST_RUN);
    take     = bus.in_valid && in_ready;
    feed     = {valid_q, take};
  end

  // Next-state valid bits: each advancing stage copies its predecessor
  // (bubbles included); flush empties the whole chain.
  always_comb begin
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (adv[k]) valid_d[k] = feed[k];
      end
    end
  end

  // Occupancy tracks the popcount of the bits about to be registered.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  // Drain handshake: stop input, wait for the registered pipe to empty,
  // then hold in DONE until resumed. Flush does not touch the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.drain_req)  state_d = ST_DRAIN;
      ST_DRAIN: if (occ_q == '0)    state_d = ST_DONE;
      ST_DONE:  if (bus.resume)     state_d = ST_RUN;
      default:                      state_d = ST_RUN;
    endcase
  end

  // State registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q[NUM_STAGES-1];
  assign bus.stage_en    = {NUM_STAGES{rst}} & adv;
  assign bus.stage_flush = rst && bus.flush;
  assign bus.valid       = valid_q;
  assign bus.occupancy   = occ_q;
  assign bus.drain_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// Bench for the vector pipeline sequencer with three stages. A bench-side
// data pipe is loaded by the DUT's stage enables; a queue of accepted tags
// is compared against whatever that pipe presents when an element leaves.
module tb_riscv_v_pipe_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  riscv_v_pipe_ctrl_if #(.NUM_STAGES(N)) bus ();

  riscv_v_pipe_ctrl #(.NUM_STAGES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int sb[$];
  int pdata[N];
  int in_tag   = 0;
  int out_cnt  = 0;
  int last_out = -1;

  logic         s_acc, s_out, s_flush;
  logic [N-1:0] s_en;

  // Sample handshake outcomes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    s_acc   = rst && bus.in_valid && bus.in_ready;
    s_out   = rst && bus.out_valid && bus.out_ready && !bus.stall && !bus.flush;
    s_flush = rst && bus.flush;
    s_en    = bus.stage_en;
  end

  // Apply sampled outcomes at the edge: pop/compare, move data, push tags.
  always @(posedge clk) begin
    if (rst) begin
      if (s_out) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got tag=%0d, expected none", pdata[N-1]);
        end else begin
          int exp_tag;
          exp_tag = sb.pop_front();
          if (pdata[N-1] !== exp_tag) begin
            bad++;
            $display("FAIL sb_order: got tag=%0d expected tag=%0d", pdata[N-1], exp_tag);
          end
          out_cnt++;
          last_out = pdata[N-1];
        end
      end
      if (s_flush) begin
        sb.delete();
      end else begin
        for (int k = N - 1; k >= 1; k--) if (s_en[k]) pdata[k] = pdata[k-1];
        if (s_en[0]) pdata[0] = in_tag;
        if (s_acc) begin
          sb.push_back(in_tag);
          in_tag++;
        end
      end
    end
  end

  always @(negedge rst) begin
    sb.delete();
    in_tag   = 0;
    out_cnt  = 0;
    last_out = -1;
    for (int k = 0; k < N; k++) pdata[k] = -1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.drain_req = 1'b0;
    bus.resume    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    #3;
    total++; if (bus.valid !== 3'b000)    begin bad++; $display("FAIL rst_valid: got %b expected 000", bus.valid); end
    total++; if (bus.occupancy !== 2'd0)  begin bad++; $display("FAIL rst_occ: got %0d expected 0", bus.occupancy); end
    total++; if (bus.drain_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b expected 0", bus.drain_done); end
    total++; if (bus.in_ready !== 1'b0)   begin bad++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    total++; if (bus.stage_en !== 3'b000) begin bad++; $display("FAIL rst_stage_en: got %b expected 000", bus.stage_en); end
    total++; if (bus.stage_flush !== 1'b0) begin bad++; $display("FAIL rst_stage_flush: got %b expected 0", bus.stage_flush); end
    total++; if (bus.out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    bus.flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill_stream();
    logic [1:0] exp_occ [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       exp_ov  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      #1;
      total++; if (bus.stage_en !== 3'b111) begin bad++; $display("FAIL fill_en[%0d]: got %b expected 111", i, bus.stage_en); end
      total++; if (bus.in_ready !== 1'b1)   begin bad++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      step();
      total++; if (bus.occupancy !== exp_occ[i]) begin bad++; $display("FAIL fill_occ[%0d]: got %0d expected %0d", i, bus.occupancy, exp_occ[i]); end
      total++; if (bus.out_valid !== exp_ov[i])  begin bad++; $display("FAIL fill_ov[%0d]: got %b expected %b", i, bus.out_valid, exp_ov[i]); end
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    total++; if (bus.valid !== 3'b000) begin bad++; $display("FAIL fill_empty: got %b expected 000", bus.valid); end
    total++; if (out_cnt !== 5)        begin bad++; $display("FAIL fill_count: got %0d expected 5", out_cnt); end
  endtask

  task automatic test_bubble();
    logic in_pat [3] = '{1'b1, 1'b0, 1'b1};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = in_pat[i];
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.valid !== 3'b101)    begin bad++; $display("FAIL bub_valid0: got %b expected 101", bus.valid); end
    total++; if (bus.stage_en !== 3'b011) begin bad++; $display("FAIL bub_en0: got %b expected 011", bus.stage_en); end
    step();
    total++; if (bus.valid !== 3'b110)    begin bad++; $display("FAIL bub_valid1: got %b expected 110", bus.valid); end
    total++; if (bus.stage_en !== 3'b001) begin bad++; $display("FAIL bub_en1: got %b expected 001", bus.stage_en); end
    bus.in_valid = 1'b1;
    step();
    total++; if (bus.valid !== 3'b111)    begin bad++; $display("FAIL bub_valid2: got %b expected 111", bus.valid); end
    total++; if (bus.stage_en !== 3'b000) begin bad++; $display("FAIL bub_en2: got %b expected 000", bus.stage_en); end
    total++; if (bus.in_ready !== 1'b0)   begin bad++; $display("FAIL bub_ready2: got %b expected 0", bus.in_ready); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    total++; if (bus.valid !== 3'b000) begin bad++; $display("FAIL bub_empty: got %b expected 000", bus.valid); end
    total++; if (sb.size() !== 0)      begin bad++; $display("FAIL bub_left: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) step();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    #1;
    total++; if (bus.stage_flush !== 1'b1) begin bad++; $display("FAIL fl_strobe: got %b expected 1", bus.stage_flush); end
    total++; if (bus.stage_en !== 3'b000)  begin bad++; $display("FAIL fl_en: got %b expected 000", bus.stage_en); end
    total++; if (bus.in_ready !== 1'b0)    begin bad++; $display("FAIL fl_ready: got %b expected 0", bus.in_ready); end
    step();
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.valid !== 3'b000)   begin bad++; $display("FAIL fl_valid: got %b expected 000", bus.valid); end
    total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL fl_occ: got %0d expected 0", bus.occupancy); end
  endtask

  task automatic test_drain();
    int zero_cyc = -1;
    int done_cyc = -1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (2) step();
    total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL dr_occ2: got %0d expected 2", bus.occupancy); end
    bus.drain_req = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL dr_ready_req: got %b expected 1", bus.in_ready); end
    step();
    bus.drain_req = 1'b0;
    total++; if (bus.occupancy !== 2'd3) begin bad++; $display("FAIL dr_kept: got %0d expected 3", bus.occupancy); end
    for (int i = 0; i < 12; i++) begin
      if (bus.drain_done === 1'b1) begin
        done_cyc = i;
        break;
      end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL dr_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      if (bus.occupancy === 2'd0 && zero_cyc < 0) zero_cyc = i;
      step();
    end
    total++;
    if (done_cyc < 0 || zero_cyc < 0 || done_cyc - zero_cyc != 1) begin
      bad++;
      $display("FAIL dr_done_timing: got zero@%0d done@%0d expected done one cycle after zero", zero_cyc, done_cyc);
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL dr_done_ready: got %b expected 0", bus.in_ready); end
    bus.drain_req = 1'b1;
    step();
    bus.drain_req = 1'b0;
    total++; if (bus.drain_done !== 1'b1) begin bad++; $display("FAIL dr_req_ignored: got %b expected 1", bus.drain_done); end
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    total++; if (bus.drain_done !== 1'b0) begin bad++; $display("FAIL dr_resume_done: got %b expected 0", bus.drain_done); end
    total++; if (bus.in_ready !== 1'b1)   begin bad++; $display("FAIL dr_resume_ready: got %b expected 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL dr_left: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) step();
    bus.in_valid  = 1'b0;
    bus.drain_req = 1'b1;
    step();
    bus.drain_req = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    total++; if (bus.valid !== 3'b000)    begin bad++; $display("FAIL rm_valid: got %b expected 000", bus.valid); end
    total++; if (bus.occupancy !== 2'd0)  begin bad++; $display("FAIL rm_occ: got %0d expected 0", bus.occupancy); end
    total++; if (bus.out_valid !== 1'b0)  begin bad++; $display("FAIL rm_ov: got %b expected 0", bus.out_valid); end
    total++; if (bus.stage_en !== 3'b000) begin bad++; $display("FAIL rm_en: got %b expected 000", bus.stage_en); end
    total++; if (bus.in_ready !== 1'b0)   begin bad++; $display("FAIL rm_ready: got %b expected 0", bus.in_ready); end
    repeat (2) step();
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1)   begin bad++; $display("FAIL rm_rel_ready: got %b expected 1", bus.in_ready); end
    total++; if (bus.drain_done !== 1'b0) begin bad++; $display("FAIL rm_rel_done: got %b expected 0", bus.drain_done); end
    total++; if (bus.occupancy !== 2'd0)  begin bad++; $display("FAIL rm_rel_occ: got %0d expected 0", bus.occupancy); end
  endtask

  task automatic test_stall();
    logic [N-1:0] v_before;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_cnt >= 10) break;
      bus.in_valid = (in_tag < 10);
      bus.stall    = (cyc == 4 || cyc == 5);
      if (bus.stall) begin
        v_before = bus.valid;
        #1;
        total++; if (bus.stage_en !== 3'b000) begin bad++; $display("FAIL st_en[%0d]: got %b expected 000", cyc, bus.stage_en); end
        total++; if (bus.in_ready !== 1'b0)   begin bad++; $display("FAIL st_ready[%0d]: got %b expected 0", cyc, bus.in_ready); end
        total++; if (bus.out_valid !== v_before[N-1]) begin bad++; $display("FAIL st_ov[%0d]: got %b expected %b", cyc, bus.out_valid, v_before[N-1]); end
        step();
        total++; if (bus.valid !== v_before) begin bad++; $display("FAIL st_hold[%0d]: got %b expected %b", cyc, bus.valid, v_before); end
      end else begin
        step();
      end
    end
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (out_cnt !== 10) begin bad++; $display("FAIL st_count: got %0d expected 10", out_cnt); end
    total++; if (last_out !== 9) begin bad++; $display("FAIL st_last: got %0d expected 9", last_out); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL st_left: got %0d pending expected 0", sb.size()); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) pdata[k] = -1;
    test_reset();
    test_fill_stream();
    test_bubble();
    test_flush();
    test_drain();
    test_reset_mid();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
